// File: rtl/fetch_pkg.sv
// Shared widths, constants, types and helpers for the instruction-fetch front end.
package fetch_pkg;

   localparam int XLEN    = 32;
   localparam int IMEM_AW = 30;
   localparam int ILEN    = 32;

   localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

   // One prefetched instruction together with the byte PC it was fetched from.
   typedef struct packed {
      logic [ILEN-1:0] instr;
      logic [XLEN-1:0] pc;
   } fetch_entry_t;

   // FS_FAULT parks the fetcher after a misaligned redirect until an aligned one arrives.
   typedef enum logic {
      FS_RUN   = 1'b0,
      FS_FAULT = 1'b1
   } fetch_state_t;

   function automatic logic is_word_aligned(input logic [XLEN-1:0] addr);
      return (addr[1:0] == 2'b00);
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// QDEPTH-entry prefetch FIFO with flush; a pop and a push may share a cycle even when full.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int QDEPTH = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      flush,
   input  logic                      push,
   input  logic                      pop,
   input  logic [ILEN-1:0]           wr_instr,
   input  logic [XLEN-1:0]           wr_pc,
   output logic [ILEN-1:0]           rd_instr,
   output logic [XLEN-1:0]           rd_pc,
   output logic [$clog2(QDEPTH):0]   count
);

   localparam int PW = $clog2(QDEPTH);
   localparam int CW = PW + 1;

   fetch_entry_t  mem [QDEPTH];
   fetch_entry_t  head;
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;

   // QDEPTH is a power of two, so the pointers wrap by plain overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         if (push && !pop)      count <= count + CW'(1);
         else if (pop && !push) count <= count - CW'(1);
      end
   end

   // NOTE: storage is deliberately not reset; the head is masked to zero while the queue is empty.
   always_ff @(posedge clk) begin
      if (push && !flush) mem[wr_ptr] <= '{instr: wr_instr, pc: wr_pc};
   end

   assign head     = mem[rd_ptr];
   assign rd_instr = (count != '0) ? head.instr : '0;
   assign rd_pc    = (count != '0) ? head.pc    : '0;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch initiator: PC, redirect/fault handling, prefetch queue, perf counters.
// Optional perf counters are built only when FETCH_PERF_EN is defined.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          QDEPTH   = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [29:0] imem_addr,
   input  logic [31:0] imem_instr,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   output logic        fetch_fault,
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_stall
);

   localparam int CW = $clog2(QDEPTH) + 1;

   fetch_state_t    state_q, state_d;
   logic [XLEN-1:0] fetch_pc, pc_d;
   logic [CW-1:0]   count;
   logic            pop;
   logic            push;
   logic            q_not_full;

   assign imem_addr   = fetch_pc[XLEN-1:2];
   assign out_valid   = (count != '0);
   assign pop         = out_valid & out_ready;
   assign q_not_full  = (count < CW'(QDEPTH));
   assign fetch_fault = (state_q == FS_FAULT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= FS_RUN;
         fetch_pc <= RESET_PC;
      end else begin
         state_q  <= state_d;
         fetch_pc <= pc_d;
      end
   end

   // NOTE: every combinational output gets a default first so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      pc_d    = fetch_pc;
      push    = 1'b0;
      case (state_q)
         FS_RUN:   push = q_not_full | pop;
         FS_FAULT: push = 1'b0;
         default:  push = 1'b0;
      endcase
      if (redirect_valid) begin
         push    = 1'b0;
         pc_d    = {redirect_pc[XLEN-1:2], 2'b00};
         state_d = is_word_aligned(redirect_pc) ? FS_RUN : FS_FAULT;
      end else if (push) begin
         pc_d = fetch_pc + XLEN'(4);
      end
   end

   // A redirect flushes the queue and drops any pop landing in the same cycle.
   fetch_queue #(
      .QDEPTH (QDEPTH)
   ) u_queue (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (redirect_valid),
      .push     (push),
      .pop      (pop & ~redirect_valid),
      .wr_instr (imem_instr),
      .wr_pc    (fetch_pc),
      .rd_instr (out_instr),
      .rd_pc    (out_pc),
      .count    (count)
   );

`ifdef FETCH_PERF_EN
   logic [31:0] fetched_q;
   logic [31:0] stall_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetched_q <= '0;
         stall_q   <= '0;
      end else begin
         if (push)                    fetched_q <= fetched_q + 32'd1;
         if (out_valid && !out_ready) stall_q   <= stall_q + 32'd1;
      end
   end

   assign perf_fetched = fetched_q;
   assign perf_stall   = stall_q;
`else
   assign perf_fetched = '0;
   assign perf_stall   = '0;
`endif

endmodule
